// File: rtl/deco_pkg.sv
// Shared definitions for the write-side port decoder: port addresses,
// command and error bit positions, the transaction state encoding and a
// port-match helper.
package deco_pkg;

    // Processor output-port addresses
    localparam logic [7:0] PUERTO_DIR  = 8'h01;
    localparam logic [7:0] PUERTO_DATO = 8'h02;
    localparam logic [7:0] PUERTO_CMD  = 8'h03;
    localparam logic [7:0] PUERTO_CLR  = 8'h04;

    // Bit positions inside the command byte
    localparam int CMD_BIT_ESCRIBE = 0;
    localparam int CMD_BIT_LEE     = 1;

    // Bit positions inside the sticky error flags
    localparam int ERR_BIT_TIMEOUT  = 0;
    localparam int ERR_BIT_COLISION = 1;

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        ESCRIBE  = 3'd1,
        ESPERA_E = 3'd2,
        LEE      = 3'd3,
        ESPERA_L = 3'd4
    } estado_t;

    // True when the processor writes the given port in this cycle
    function automatic logic es_escritura(input logic       strobe,
                                          input logic [7:0] port_id,
                                          input logic [7:0] puerto);
        return strobe && (port_id == puerto);
    endfunction

endpackage

// File: rtl/deco_temporizador.sv
// Timeout counter for the ESPERA states. Cleared by inicio (the cycle
// before the wait starts), counts while activo, and flags vencido while
// sitting on the terminal count TIMEOUT_CICLOS-1.
// Only instantiated when DECO_TIMEOUT_EN is defined.
module deco_temporizador #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic inicio,
    input  logic activo,
    output logic vencido
);

    localparam int W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [W-1:0] TERMINAL = W'(TIMEOUT_CICLOS - 1);

    logic [W-1:0] r_cuenta;

    // Wait-cycle counter: restart on entry, saturate at the terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cuenta <= {W{1'b0}};
        end else if (inicio) begin
            r_cuenta <= {W{1'b0}};
        end else if (activo && (r_cuenta != TERMINAL)) begin
            r_cuenta <= r_cuenta + W'(1);
        end else begin
            r_cuenta <= r_cuenta;
        end
    end

    assign vencido = activo && (r_cuenta == TERMINAL);

endmodule

// File: rtl/deco_escritura_puerto.sv
// Write-side port decoder: captures address/data port writes, turns
// command writes into one-cycle start strobes for the write/read bus
// engines and tracks each transaction to its done flag, producing the
// listo / ocupado / error status and the captured read data.
// Optional feature: DECO_TIMEOUT_EN adds a wait timeout (error[0]).
module deco_escritura_puerto
    import deco_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       listo_escribe,
    input  logic       listo_lee,
    input  logic [7:0] dato_bus,
    output logic       inicia_escribe,
    output logic       inicia_lee,
    output logic [7:0] direccion,
    output logic [7:0] dato_escribe,
    output logic [7:0] dato_leido,
    output logic       listo,
    output logic       ocupado,
    output logic [1:0] error
);

    if (TIMEOUT_CICLOS < 2) begin : g_param_check
        $error("deco_escritura_puerto: TIMEOUT_CICLOS must be at least 2");
    end

    estado_t    r_estado;
    logic       r_inicia_escribe;
    logic       r_inicia_lee;
    logic [7:0] r_direccion;
    logic [7:0] r_dato_escribe;
    logic [7:0] r_dato_leido;
    logic       r_listo;
    logic       r_ocupado;
    logic [1:0] r_error;

    logic w_wr_dir;
    logic w_wr_dato;
    logic w_wr_cmd;
    logic w_wr_clr;
    logic w_vencido;

    assign w_wr_dir  = es_escritura(write_strobe, port_id, PUERTO_DIR);
    assign w_wr_dato = es_escritura(write_strobe, port_id, PUERTO_DATO);
    assign w_wr_cmd  = es_escritura(write_strobe, port_id, PUERTO_CMD);
    assign w_wr_clr  = es_escritura(write_strobe, port_id, PUERTO_CLR);

`ifdef DECO_TIMEOUT_EN
    logic w_inicio_espera;
    logic w_en_espera;

    // ESCRIBE/LEE always last one cycle, so they mark the wait entry
    assign w_inicio_espera = (r_estado == ESCRIBE) || (r_estado == LEE);
    assign w_en_espera     = (r_estado == ESPERA_E) || (r_estado == ESPERA_L);

    deco_temporizador #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_temporizador (
        .clk     (clk),
        .reset   (reset),
        .inicio  (w_inicio_espera),
        .activo  (w_en_espera),
        .vencido (w_vencido)
    );
`else
    assign w_vencido = 1'b0;
`endif

    // Transaction FSM with registered strobes, status and captured data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado         <= REPOSO;
            r_inicia_escribe <= 1'b0;
            r_inicia_lee     <= 1'b0;
            r_direccion      <= 8'h00;
            r_dato_escribe   <= 8'h00;
            r_dato_leido     <= 8'h00;
            r_listo          <= 1'b0;
            r_ocupado        <= 1'b0;
            r_error          <= 2'b00;
        end else begin
            r_inicia_escribe <= 1'b0;
            r_inicia_lee     <= 1'b0;

            // Address/data stay writable while busy; engines latch at the strobe
            if (w_wr_dir) begin
                r_direccion <= out_port;
            end
            if (w_wr_dato) begin
                r_dato_escribe <= out_port;
            end

            // Clear first so any set event later in this block overrides it
            if (w_wr_clr) begin
                r_listo <= 1'b0;
                r_error <= 2'b00;
            end

            case (r_estado)
                REPOSO: begin
                    if (w_wr_cmd && out_port[CMD_BIT_ESCRIBE]) begin
                        // Write wins when both bits are set; read is dropped
                        r_estado         <= ESCRIBE;
                        r_inicia_escribe <= 1'b1;
                        r_ocupado        <= 1'b1;
                        r_listo          <= 1'b0;
                    end else if (w_wr_cmd && out_port[CMD_BIT_LEE]) begin
                        r_estado     <= LEE;
                        r_inicia_lee <= 1'b1;
                        r_ocupado    <= 1'b1;
                        r_listo      <= 1'b0;
                    end
                end
                ESCRIBE: begin
                    r_estado <= ESPERA_E;
                end
                ESPERA_E: begin
                    // A done flag on the terminal count beats the timeout
                    if (listo_escribe) begin
                        r_estado  <= REPOSO;
                        r_listo   <= 1'b1;
                        r_ocupado <= 1'b0;
                    end else if (w_vencido) begin
                        r_estado                 <= REPOSO;
                        r_ocupado                <= 1'b0;
                        r_error[ERR_BIT_TIMEOUT] <= 1'b1;
                    end
                end
                LEE: begin
                    r_estado <= ESPERA_L;
                end
                ESPERA_L: begin
                    if (listo_lee) begin
                        r_estado     <= REPOSO;
                        r_listo      <= 1'b1;
                        r_ocupado    <= 1'b0;
                        r_dato_leido <= dato_bus;
                    end else if (w_vencido) begin
                        r_estado                 <= REPOSO;
                        r_ocupado                <= 1'b0;
                        r_error[ERR_BIT_TIMEOUT] <= 1'b1;
                    end
                end
                default: begin
                    r_estado  <= REPOSO;
                    r_ocupado <= 1'b0;
                end
            endcase

            // A command while busy is discarded and flagged
            if (w_wr_cmd && r_ocupado) begin
                r_error[ERR_BIT_COLISION] <= 1'b1;
            end
        end
    end

    assign inicia_escribe = r_inicia_escribe;
    assign inicia_lee     = r_inicia_lee;
    assign direccion      = r_direccion;
    assign dato_escribe   = r_dato_escribe;
    assign dato_leido     = r_dato_leido;
    assign listo          = r_listo;
    assign ocupado        = r_ocupado;
    assign error          = r_error;

endmodule

// File: tb/tb_deco_escritura_puerto.sv
// Scoreboard bench for deco_escritura_puerto. Stimulus pushes expected
// strobes, transaction completions and status snapshots into queues; a
// monitor on the falling edge pops and compares them as the DUT shows them.
module tb_deco_escritura_puerto;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       write_strobe = 1'b0;
    logic       listo_escribe = 1'b0;
    logic       listo_lee = 1'b0;
    logic [7:0] dato_bus = 8'h00;
    logic       inicia_escribe;
    logic       inicia_lee;
    logic [7:0] direccion;
    logic [7:0] dato_escribe;
    logic [7:0] dato_leido;
    logic       listo;
    logic       ocupado;
    logic [1:0] error;

    deco_escritura_puerto #(.TIMEOUT_CICLOS(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .port_id        (port_id),
        .out_port       (out_port),
        .write_strobe   (write_strobe),
        .listo_escribe  (listo_escribe),
        .listo_lee      (listo_lee),
        .dato_bus       (dato_bus),
        .inicia_escribe (inicia_escribe),
        .inicia_lee     (inicia_lee),
        .direccion      (direccion),
        .dato_escribe   (dato_escribe),
        .dato_leido     (dato_leido),
        .listo          (listo),
        .ocupado        (ocupado),
        .error          (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] kind;   // {inicia_lee, inicia_escribe}
        logic [7:0] dir;
        logic [7:0] dat;
    } strobe_t;

    typedef struct {
        logic       listo;
        logic [1:0] err;
        logic [7:0] leido;
        int         lat;    // negedges from strobe to ocupado low; -1 = not checked
    } fin_t;

    typedef struct {
        logic [7:0] dir;
        logic [7:0] dat;
        logic [7:0] leido;
        logic       listo;
        logic       ocup;
        logic [1:0] err;
        logic       ie;
        logic       il;
    } snap_t;

    strobe_t q_strobe[$];
    fin_t    q_fin[$];
    snap_t   q_snap[$];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   strobe_cyc = 0;
    logic prev_ocup = 1'b0;
    logic snap_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queues
    always @(negedge clk) begin
        strobe_t s;
        fin_t    f;
        snap_t   p;
        cyc++;
        if (snap_req) begin
            if (q_snap.size() == 0) begin
                chk("snap_queue_empty", 32'd1, 32'd0);
            end else begin
                p = q_snap.pop_front();
                chk("snap_direccion", 32'(direccion), 32'(p.dir));
                chk("snap_dato_escribe", 32'(dato_escribe), 32'(p.dat));
                chk("snap_dato_leido", 32'(dato_leido), 32'(p.leido));
                chk("snap_listo", 32'(listo), 32'(p.listo));
                chk("snap_ocupado", 32'(ocupado), 32'(p.ocup));
                chk("snap_error", 32'(error), 32'(p.err));
                chk("snap_inicia_escribe", 32'(inicia_escribe), 32'(p.ie));
                chk("snap_inicia_lee", 32'(inicia_lee), 32'(p.il));
            end
        end
        if (reset) begin
            prev_ocup = 1'b0;
        end else begin
            if (inicia_escribe || inicia_lee) begin
                strobe_cyc = cyc;
                if (q_strobe.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, inicia_lee, inicia_escribe}, 32'd0);
                end else begin
                    s = q_strobe.pop_front();
                    chk("strobe_kind", {30'd0, inicia_lee, inicia_escribe}, 32'(s.kind));
                    chk("strobe_direccion", 32'(direccion), 32'(s.dir));
                    if (s.kind == 2'b01) begin
                        chk("strobe_dato_escribe", 32'(dato_escribe), 32'(s.dat));
                    end
                end
            end
            if (prev_ocup && !ocupado) begin
                if (q_fin.size() == 0) begin
                    chk("unexpected_fin", 32'd1, 32'd0);
                end else begin
                    f = q_fin.pop_front();
                    chk("fin_listo", 32'(listo), 32'(f.listo));
                    chk("fin_error", 32'(error), 32'(f.err));
                    chk("fin_dato_leido", 32'(dato_leido), 32'(f.leido));
                    if (f.lat >= 0) begin
                        chk("fin_latency", 32'(cyc - strobe_cyc), 32'(f.lat));
                    end
                end
            end
            prev_ocup = ocupado;
        end
    end

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        @(posedge clk); #1;
        port_id = p; out_port = d; write_strobe = 1'b1;
        @(posedge clk); #1;
        write_strobe = 1'b0; port_id = 8'h00;
    endtask

    // Done pulses sampled k+1 edges after the call when called right after wr
    task automatic done_w(input int k);
        repeat (k) @(posedge clk);
        #1 listo_escribe = 1'b1;
        @(posedge clk); #1;
        listo_escribe = 1'b0;
    endtask

    task automatic done_r(input int k, input logic [7:0] d);
        repeat (k) @(posedge clk);
        #1 listo_lee = 1'b1; dato_bus = d;
        @(posedge clk); #1;
        listo_lee = 1'b0; dato_bus = 8'h00;
    endtask

    task automatic snap(input logic [7:0] dir, input logic [7:0] dat, input logic [7:0] leido,
                        input logic lst, input logic ocup, input logic [1:0] err,
                        input logic ie, input logic il);
        snap_t p;
        p.dir = dir; p.dat = dat; p.leido = leido; p.listo = lst;
        p.ocup = ocup; p.err = err; p.ie = ie; p.il = il;
        q_snap.push_back(p);
        snap_req = 1'b1;
        @(negedge clk); #1;
        snap_req = 1'b0;
    endtask

    task automatic exp_strobe(input logic [1:0] kind, input logic [7:0] dir, input logic [7:0] dat);
        strobe_t s;
        s.kind = kind; s.dir = dir; s.dat = dat;
        q_strobe.push_back(s);
    endtask

    task automatic exp_fin(input logic lst, input logic [1:0] err, input logic [7:0] leido, input int lat);
        fin_t f;
        f.listo = lst; f.err = err; f.leido = leido; f.lat = lat;
        q_fin.push_back(f);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        snap(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1 reset = 1'b0;

        // Write transaction, engine answers after 5 cycles
        wr(8'h01, 8'h21);
        wr(8'h02, 8'hD2);
        exp_strobe(2'b01, 8'h21, 8'hD2);
        exp_fin(1'b1, 2'b00, 8'h00, 6);
        wr(8'h03, 8'h01);
        done_w(5);
        snap(8'h21, 8'hD2, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

        // Done flag while idle is ignored
        done_r(0, 8'h55);
        snap(8'h21, 8'hD2, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

        // Read transaction with immediate engine response
        exp_strobe(2'b10, 8'h21, 8'h00);
        exp_fin(1'b1, 2'b00, 8'hF1, 2);
        wr(8'h03, 8'h02);
        done_r(1, 8'hF1);

        // Both bits: write only; then wrong-engine done, collision, busy reg write
        exp_strobe(2'b01, 8'h21, 8'hD2);
        wr(8'h03, 8'h03);
        snap(8'h21, 8'hD2, 8'hF1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
        done_r(0, 8'h99);
        wr(8'h03, 8'h02);
        wr(8'h01, 8'h44);
        snap(8'h44, 8'hD2, 8'hF1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        exp_fin(1'b1, 2'b10, 8'hF1, -1);
        done_w(0);
        wr(8'h04, 8'h00);
        snap(8'h44, 8'hD2, 8'hF1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Clear coinciding with done: listo set wins
        exp_strobe(2'b01, 8'h44, 8'hD2);
        exp_fin(1'b1, 2'b00, 8'hF1, 4);
        wr(8'h03, 8'h01);
        repeat (3) @(posedge clk);
        #1 listo_escribe = 1'b1; port_id = 8'h04; write_strobe = 1'b1;
        @(posedge clk); #1;
        listo_escribe = 1'b0; port_id = 8'h00; write_strobe = 1'b0;
        snap(8'h44, 8'hD2, 8'hF1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

`ifdef DECO_TIMEOUT_EN
        // Timeout: no done flag at all
        exp_strobe(2'b01, 8'h44, 8'hD2);
        exp_fin(1'b0, 2'b01, 8'hF1, 9);
        wr(8'h03, 8'h01);
        repeat (12) @(posedge clk);
        snap(8'h44, 8'hD2, 8'hF1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        wr(8'h04, 8'h00);
        // Done on the terminal count beats the timeout
        exp_strobe(2'b01, 8'h44, 8'hD2);
        exp_fin(1'b1, 2'b00, 8'hF1, 9);
        wr(8'h03, 8'h01);
        done_w(8);
`else
        // Without the timeout the wait is indefinite
        exp_strobe(2'b01, 8'h44, 8'hD2);
        wr(8'h03, 8'h01);
        repeat (20) @(posedge clk);
        snap(8'h44, 8'hD2, 8'hF1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        exp_fin(1'b1, 2'b00, 8'hF1, -1);
        done_w(0);
`endif

        // Reset during ESPERA_L: outputs drop before any clock edge
        exp_strobe(2'b10, 8'h44, 8'h00);
        wr(8'h03, 8'h02);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        snap(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        done_r(0, 8'h77);
        repeat (2) @(posedge clk);
        snap(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("pending_strobes", 32'(q_strobe.size()), 32'd0);
        chk("pending_fins", 32'(q_fin.size()), 32'd0);
        chk("pending_snaps", 32'(q_snap.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
